// File: rtl/mac_pipe_if.sv
// mac_pipe_if: handshake and data bundle for the mac_pipe multiply-accumulate
// pipeline.
//
// Parameters mirror mac_pipe: A_SIZE, B_SIZE, C_SIZE, DATA_SIZE.
// Signals:
//   in_valid  / in_ready  : input handshake (A, B, C, mode qualified by in_valid)
//   A, B, C, mode         : operands, addend, 0 = per-sample, 1 = accumulate
//   out_valid / out_ready : output handshake (DATA_OUT, ovf qualified by out_valid)
//   DATA_OUT, ovf         : result and overflow flag
//   grp_cnt               : beats accumulated in the current mode-1 group
// Modports: master = stimulus / upstream+downstream side, slave = mac_pipe.
interface mac_pipe_if #(
  parameter int A_SIZE    = 8,
  parameter int B_SIZE    = 8,
  parameter int C_SIZE    = 16,
  parameter int DATA_SIZE = 20
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [A_SIZE-1:0]    A;
  logic [B_SIZE-1:0]    B;
  logic [C_SIZE-1:0]    C;
  logic                 mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_SIZE-1:0] DATA_OUT;
  logic                 ovf;
  logic [7:0]           grp_cnt;

  modport master (
    output in_valid, A, B, C, mode, out_ready,
    input  in_ready, out_valid, DATA_OUT, ovf, grp_cnt
  );

  modport slave (
    input  in_valid, A, B, C, mode, out_ready,
    output in_ready, out_valid, DATA_OUT, ovf, grp_cnt
  );
endinterface

// File: rtl/mac_pipe.sv
// mac_pipe: three-stage unsigned multiply-accumulate pipeline.
//   S1 registers A, B, C, mode; S2 registers the full-width product A*B with
//   delayed C/mode; S3 adds and drives the registered outputs.
//   mode 0 : DATA_OUT = A*B + C, one result per accepted beat.
//   mode 1 : ACC_LEN beats form a group; first beat loads A*B + C, later beats
//            add A*B (C ignored); one result on the last beat of the group.
//   A single advance enable stalls every stage while a result is waiting on
//   out_ready; in_ready equals that enable.
//   DATA_SIZE must be >= max(A_SIZE+B_SIZE, C_SIZE).
//
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mac_pipe_if.slave (in_valid/in_ready, A, B, C, mode,
//           out_valid/out_ready, DATA_OUT, ovf, grp_cnt)
//
// Build option: define MAC_PIPE_SAT_EN to saturate DATA_OUT (and the group
// accumulator) at 2^DATA_SIZE-1 on overflow; otherwise results wrap.
module mac_pipe #(
  parameter int A_SIZE    = 8,
  parameter int B_SIZE    = 8,
  parameter int C_SIZE    = 16,
  parameter int DATA_SIZE = 20,
  parameter int ACC_LEN   = 4
) (
  input logic       clk,
  input logic       rst_n,
  mac_pipe_if.slave bus
);
  localparam int         P_SIZE   = A_SIZE + B_SIZE;
  localparam int         S_SIZE   = DATA_SIZE + 1;
  localparam logic [7:0] LAST_CNT = 8'(ACC_LEN - 1);

  logic                 en_s;

  logic                 s1_valid_r;
  logic [A_SIZE-1:0]    s1_a_r;
  logic [B_SIZE-1:0]    s1_b_r;
  logic [C_SIZE-1:0]    s1_c_r;
  logic                 s1_mode_r;

  logic                 s2_valid_r;
  logic [P_SIZE-1:0]    s2_prod_r;
  logic [C_SIZE-1:0]    s2_c_r;
  logic                 s2_mode_r;

  logic [DATA_SIZE-1:0] acc_r;
  logic                 grp_ovf_r;
  logic [7:0]           grp_cnt_r;
  logic                 out_valid_r;
  logic [DATA_SIZE-1:0] data_out_r;
  logic                 ovf_r;

  logic                 first_s;
  logic                 last_s;
  logic [S_SIZE-1:0]    base_s;
  logic [S_SIZE-1:0]    sum_s;
  logic                 grp_ovf_s;
  logic [DATA_SIZE-1:0] res_s;

  // The whole pipeline only stalls when a result is held for downstream.
  assign en_s          = !(out_valid_r && !bus.out_ready);
  assign bus.in_ready  = en_s;
  assign bus.out_valid = out_valid_r;
  assign bus.DATA_OUT  = data_out_r;
  assign bus.ovf       = ovf_r;
  assign bus.grp_cnt   = grp_cnt_r;

  // Stage 1: capture the input beat (in_valid doubles as the stage valid).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
      s1_c_r     <= '0;
      s1_mode_r  <= 1'b0;
    end else if (en_s) begin
      s1_valid_r <= bus.in_valid;
      s1_a_r     <= bus.A;
      s1_b_r     <= bus.B;
      s1_c_r     <= bus.C;
      s1_mode_r  <= bus.mode;
    end
  end

  // Stage 2: full-width product plus delayed addend and mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_prod_r  <= '0;
      s2_c_r     <= '0;
      s2_mode_r  <= 1'b0;
    end else if (en_s) begin
      s2_valid_r <= s1_valid_r;
      s2_prod_r  <= P_SIZE'(s1_a_r) * P_SIZE'(s1_b_r);
      s2_c_r     <= s1_c_r;
      s2_mode_r  <= s1_mode_r;
    end
  end

  // Stage 3 datapath: pick the addend, add with carry, fold in sticky overflow.
  always_comb begin
    // A mode-0 beat always starts fresh, discarding any partial group.
    first_s = (grp_cnt_r == 8'd0) || !s2_mode_r;
    last_s  = (grp_cnt_r == LAST_CNT);
    if (first_s) begin
      base_s = S_SIZE'(s2_c_r);
    end else begin
      base_s = S_SIZE'(acc_r);
    end
    sum_s = S_SIZE'(s2_prod_r) + base_s;
    if (first_s) begin
      grp_ovf_s = sum_s[DATA_SIZE];
    end else begin
      grp_ovf_s = sum_s[DATA_SIZE] | grp_ovf_r;
    end
`ifdef MAC_PIPE_SAT_EN
    // Once the group has overflowed, the result and the accumulator pin at max.
    if (grp_ovf_s) begin
      res_s = {DATA_SIZE{1'b1}};
    end else begin
      res_s = sum_s[DATA_SIZE-1:0];
    end
`else
    res_s = sum_s[DATA_SIZE-1:0];
`endif
  end

  // Stage 3 state: accumulator, group counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= '0;
      grp_ovf_r   <= 1'b0;
      grp_cnt_r   <= 8'd0;
      out_valid_r <= 1'b0;
      data_out_r  <= '0;
      ovf_r       <= 1'b0;
    end else if (en_s) begin
      if (s2_valid_r) begin
        if (!s2_mode_r || last_s) begin
          out_valid_r <= 1'b1;
          data_out_r  <= res_s;
          ovf_r       <= grp_ovf_s;
          grp_cnt_r   <= 8'd0;
          acc_r       <= '0;
          grp_ovf_r   <= 1'b0;
        end else begin
          out_valid_r <= 1'b0;
          acc_r       <= res_s;
          grp_ovf_r   <= grp_ovf_s;
          grp_cnt_r   <= grp_cnt_r + 8'd1;
        end
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: directed self-checking bench for mac_pipe.
//   dut   : default parameters (DATA_SIZE 20, ACC_LEN 4)
//   dut16 : DATA_SIZE 16, ACC_LEN 2 for the overflow / saturation cases
module tb_mac_pipe;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mac_pipe_if #(.A_SIZE(8), .B_SIZE(8), .C_SIZE(16), .DATA_SIZE(20)) bus ();
  mac_pipe_if #(.A_SIZE(8), .B_SIZE(8), .C_SIZE(16), .DATA_SIZE(16)) bus16 ();

  mac_pipe #(.A_SIZE(8), .B_SIZE(8), .C_SIZE(16), .DATA_SIZE(20), .ACC_LEN(4))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  mac_pipe #(.A_SIZE(8), .B_SIZE(8), .C_SIZE(16), .DATA_SIZE(16), .ACC_LEN(2))
    dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

`ifdef MAC_PIPE_SAT_EN
  localparam logic [31:0] EXP16_M0 = 32'h0000_FFFF;
  localparam logic [31:0] EXP16_M1 = 32'h0000_FFFF;
`else
  localparam logic [31:0] EXP16_M0 = 32'h0000_FE00;
  localparam logic [31:0] EXP16_M1 = 32'h0000_FE01;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] c, input logic m);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.C        = c;
    bus.mode     = m;
  endtask

  task automatic drive16(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] c, input logic m);
    bus16.in_valid = v;
    bus16.A        = a;
    bus16.B        = b;
    bus16.C        = c;
    bus16.mode     = m;
  endtask

  logic [31:0] stream_exp [6];
  logic [31:0] held;
  int          n_in;
  int          n_out;
  int          stall;
  int          seen;
  int          n_res;

  initial begin
    checks = 0;
    errors = 0;
    stream_exp[0] = 32'd3;
    stream_exp[1] = 32'd10;
    stream_exp[2] = 32'd19;
    stream_exp[3] = 32'd30;
    stream_exp[4] = 32'd43;
    stream_exp[5] = 32'd58;
    rst_n = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
    drive16(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
    bus.out_ready   = 1'b1;
    bus16.out_ready = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.DATA_OUT), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_grp_cnt", 32'(bus.grp_cnt), 32'd0);
    #8 rst_n = 1'b1;
    tick();
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Mode 0: 3*4+5 appears three edges after acceptance
    drive(1'b1, 8'd3, 8'd4, 16'd5, 1'b0);
    tick();
    drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
    check("m0_lat_e1", 32'(bus.out_valid), 32'd0);
    tick();
    check("m0_lat_e2", 32'(bus.out_valid), 32'd0);
    tick();
    check("m0_valid", 32'(bus.out_valid), 32'd1);
    check("m0_data", 32'(bus.DATA_OUT), 32'd17);
    check("m0_ovf", 32'(bus.ovf), 32'd0);
    tick();
    check("m0_single", 32'(bus.out_valid), 32'd0);

    // Mode 1 group of 4: 2+12+30+56+10 = 110, C ignored after first beat
    drive(1'b1, 8'd1, 8'd2, 16'd10, 1'b1);
    tick();
    drive(1'b1, 8'd3, 8'd4, 16'd99, 1'b1);
    tick();
    drive(1'b1, 8'd5, 8'd6, 16'd99, 1'b1);
    tick();
    check("m1_grp1", 32'(bus.grp_cnt), 32'd1);
    check("m1_nv1", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 8'd7, 8'd8, 16'd99, 1'b1);
    tick();
    check("m1_grp2", 32'(bus.grp_cnt), 32'd2);
    check("m1_nv2", 32'(bus.out_valid), 32'd0);
    drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
    tick();
    check("m1_grp3", 32'(bus.grp_cnt), 32'd3);
    check("m1_nv3", 32'(bus.out_valid), 32'd0);
    tick();
    check("m1_grp0", 32'(bus.grp_cnt), 32'd0);
    check("m1_valid", 32'(bus.out_valid), 32'd1);
    check("m1_data", 32'(bus.DATA_OUT), 32'd110);
    check("m1_ovf", 32'(bus.ovf), 32'd0);
    tick();
    check("m1_single", 32'(bus.out_valid), 32'd0);

    // Partial mode-1 group interrupted by a mode-0 beat
    drive(1'b1, 8'd1, 8'd1, 16'd7, 1'b1);
    tick();
    drive(1'b1, 8'd2, 8'd2, 16'd0, 1'b1);
    tick();
    drive(1'b1, 8'd2, 8'd2, 16'd1, 1'b0);
    tick();
    drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
    check("drop_grp1", 32'(bus.grp_cnt), 32'd1);
    tick();
    check("drop_grp2", 32'(bus.grp_cnt), 32'd2);
    check("drop_nv", 32'(bus.out_valid), 32'd0);
    tick();
    check("drop_valid", 32'(bus.out_valid), 32'd1);
    check("drop_data", 32'(bus.DATA_OUT), 32'd5);
    check("drop_grp0", 32'(bus.grp_cnt), 32'd0);
    tick();

    // Mode-0 stream of 6 with a 3-cycle downstream stall
    n_in  = 0;
    n_out = 0;
    stall = 0;
    seen  = 0;
    held  = 32'd0;
    for (int cyc = 0; cyc < 60 && n_out < 6; cyc++) begin
      if (bus.out_valid && seen == 0) begin
        seen  = 1;
        stall = 3;
        held  = 32'(bus.DATA_OUT);
      end
      bus.out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_data", 32'(bus.DATA_OUT), held);
        stall--;
      end else if (bus.out_valid) begin
        check("stream_data", 32'(bus.DATA_OUT), stream_exp[n_out]);
        n_out++;
      end
      if (n_in < 6) begin
        drive(1'b1, 8'(n_in + 1), 8'(n_in + 2), 16'(3 * n_in + 1), 1'b0);
        if (bus.in_ready) n_in++;
      end else begin
        drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
      end
      tick();
    end
    drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
    bus.out_ready = 1'b1;
    check("stream_count", 32'(n_out), 32'd6);
    check("stream_no_dup", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a mode-1 group
    drive(1'b1, 8'd10, 8'd10, 16'd0, 1'b1);
    tick();
    drive(1'b1, 8'd20, 8'd20, 16'd0, 1'b1);
    tick();
    drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
    tick();
    tick();
    check("mid_grp2", 32'(bus.grp_cnt), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data", 32'(bus.DATA_OUT), 32'd0);
    check("mid_rst_grp", 32'(bus.grp_cnt), 32'd0);
    check("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("mid_in_ready", 32'(bus.in_ready), 32'd1);
    // 1*1+2 + 2*2 + 1*3 + 2*1 = 12
    drive(1'b1, 8'd1, 8'd1, 16'd2, 1'b1);
    tick();
    drive(1'b1, 8'd2, 8'd2, 16'd50, 1'b1);
    tick();
    drive(1'b1, 8'd1, 8'd3, 16'd50, 1'b1);
    tick();
    drive(1'b1, 8'd2, 8'd1, 16'd50, 1'b1);
    n_res = (bus.out_valid) ? 1 : 0;
    held  = 32'(bus.DATA_OUT);
    tick();
    drive(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (bus.out_valid) begin
        n_res++;
        held = 32'(bus.DATA_OUT);
      end
      tick();
    end
    check("post_rst_count", 32'(n_res), 32'd1);
    check("post_rst_data", held, 32'd12);
    check("post_rst_grp", 32'(bus.grp_cnt), 32'd0);

    // DATA_SIZE 16: 255*255 + 65535 overflows
    drive16(1'b1, 8'd255, 8'd255, 16'hFFFF, 1'b0);
    tick();
    drive16(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
    tick();
    tick();
    check("ovf16_valid", 32'(bus16.out_valid), 32'd1);
    check("ovf16_data", 32'(bus16.DATA_OUT), EXP16_M0);
    check("ovf16_flag", 32'(bus16.ovf), 32'd1);
    // Mode-1 group whose overflow happens on the first beat only
    drive16(1'b1, 8'd255, 8'd255, 16'hFFFF, 1'b1);
    tick();
    drive16(1'b1, 8'd1, 8'd1, 16'd0, 1'b1);
    tick();
    drive16(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
    tick();
    check("sticky16_nv", 32'(bus16.out_valid), 32'd0);
    tick();
    check("sticky16_valid", 32'(bus16.out_valid), 32'd1);
    check("sticky16_data", 32'(bus16.DATA_OUT), EXP16_M1);
    check("sticky16_ovf", 32'(bus16.ovf), 32'd1);
    // Next group starts with ovf cleared: 1 + 1 + 1 = 3
    drive16(1'b1, 8'd1, 8'd1, 16'd1, 1'b1);
    tick();
    drive16(1'b1, 8'd1, 8'd1, 16'd0, 1'b1);
    tick();
    drive16(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
    tick();
    tick();
    check("clr16_valid", 32'(bus16.out_valid), 32'd1);
    check("clr16_data", 32'(bus16.DATA_OUT), 32'd3);
    check("clr16_ovf", 32'(bus16.ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_pipe.md
MAC_PIPE -- requirements
Module: mac_pipe

Interface
REQ-001 Parameter A_SIZE, default 8, width of unsigned operand A.
REQ-002 Parameter B_SIZE, default 8, width of unsigned operand B.
REQ-003 Parameter C_SIZE, default 16, width of unsigned addend C.
REQ-004 Parameter DATA_SIZE, default 20, result width; SHALL be >= max(A_SIZE+B_SIZE, C_SIZE).
REQ-005 Parameter ACC_LEN, default 4, products per accumulation group in mode 1; range 2..256.
REQ-006 clk  input  1  single clock; all state on posedge clk.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 in_valid  input  1  A/B/C/mode valid this cycle.
REQ-009 in_ready  output  1  block accepts input this cycle.
REQ-010 A  input  A_SIZE  operand A.
REQ-011 B  input  B_SIZE  operand B.
REQ-012 C  input  C_SIZE  addend.
REQ-013 mode  input  1  0 = per-sample A*B+C; 1 = accumulate ACC_LEN products plus C.
REQ-014 out_valid  output  1  DATA_OUT/ovf valid.
REQ-015 out_ready  input  1  downstream accepts result.
REQ-016 DATA_OUT  output  DATA_SIZE  result.
REQ-017 ovf  output  1  result exceeded 2^DATA_SIZE-1; qualified by out_valid.
REQ-018 grp_cnt  output  8  beats accumulated in current mode-1 group (0..ACC_LEN-1).

Function
REQ-019 Three-stage pipeline: S1 registers A,B,C,mode; S2 registers A*B (full A_SIZE+B_SIZE bits) and delayed C/mode; S3 adds and drives outputs.
REQ-020 Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
REQ-021 Global advance enable en = !(out_valid && !out_ready); in_ready = en; all stages, including valid bits, hold when en = 0.
REQ-022 While stalled DATA_OUT, ovf, out_valid SHALL remain stable.
REQ-023 Mode 0: DATA_OUT = A*B + C; out_valid asserted 3 cycles after acceptance with no stall; throughput 1/cycle.
REQ-024 Mode 1: first beat of group loads acc = A*B + C; later beats acc = acc + A*B, C ignored; grp_cnt increments per beat entering S3.
REQ-025 Mode 1: on ACC_LEN-th beat out_valid asserts with final acc, grp_cnt wraps to 0; no out_valid for non-final beats.
REQ-026 Mode-0 beat reaching S3 while grp_cnt != 0 SHALL discard the partial group (grp_cnt := 0) and produce its own mode-0 result.
REQ-027 Bubbles (in_valid = 0) SHALL not affect acc or grp_cnt.
REQ-028 Sum computed DATA_SIZE+1 bits wide; ovf = carry-out; in mode 1 ovf is sticky across the group and cleared at group start.
REQ-029 Without saturation, DATA_OUT = sum modulo 2^DATA_SIZE.

Reset
REQ-030 rst_n low SHALL asynchronously clear all pipeline valids, acc, grp_cnt, out_valid, ovf, DATA_OUT to 0.
REQ-031 in_ready SHALL be 1 from first clock edge after rst_n deasserts.
REQ-032 Reset mid-group SHALL discard partial accumulation; no result for that group emitted.

Configuration
REQ-033 Macro MAC_PIPE_SAT_EN defined: when ovf would be 1, DATA_OUT = 2^DATA_SIZE-1 and acc held at that value for rest of group; ovf still reported.
REQ-034 Macro MAC_PIPE_SAT_EN undefined: wrap-around per REQ-029; no saturation logic synthesised.

Verification
REQ-035 Mode 0, defaults, A=3 B=4 C=5 cycle 0, out_ready=1 -> out_valid cycle 3, DATA_OUT=17, ovf=0.
REQ-036 Mode 1, ACC_LEN=4, beats (A,B)=(1,2),(3,4),(5,6),(7,8), C=10 on first -> single out_valid, DATA_OUT=110, grp_cnt 1,2,3,0.
REQ-037 Mode 0 stream of 6 beats, out_ready=0 for 3 cycles after first out_valid -> in_ready low during stall, no result lost or duplicated, order preserved.
REQ-038 DATA_SIZE=16, A=B=255, C=65535 mode 0 -> ovf=1; DATA_OUT=0xFE00 without MAC_PIPE_SAT_EN, 0xFFFF with it.
REQ-039 Mode 1 two beats then mode-0 beat A=2 B=2 C=1 -> partial dropped, DATA_OUT=5, grp_cnt=0.
REQ-040 rst_n pulsed low after 2 mode-1 beats -> outputs 0 immediately; next 4 beats yield one result equal to their own sum only.
